// File: rtl/lc_pkg.sv
// Shared datapath types for the CPU register file and decoder.
// Provides word_t, reg_addr_t, default sizes and the REG_ZERO address.
package lc_pkg;

    localparam int WORD_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    localparam int REG_AW       = $clog2(NUM_REGS_DEF);

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef logic [REG_AW-1:0]     reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register write select: resolves which write port wins each register.
// Ports: wr_en/wr_addr/wr_data in; reg_we (per reg), reg_wdata (packed) out.
module regfile_wr_arb
    import lc_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_WR   = 2
) (
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [NUM_WR*WORD_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0]        reg_we,
    output logic [NUM_REGS*WORD_W-1:0] reg_wdata
);

    localparam int AW = $clog2(NUM_REGS);

    // Ports scanned low to high so the highest active index wins.
    always_comb begin
        logic [AW-1:0] wa;
        wa        = '0;
        reg_we    = '0;
        reg_wdata = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wa = wr_addr[j*AW +: AW];
            if (wr_en[j]) begin
                reg_we[wa] = 1'b1;
                reg_wdata[wa*WORD_W +: WORD_W] = wr_data[j*WORD_W +: WORD_W];
            end
        end
        // r0 is hardwired to zero.
        reg_we[AW'(REG_ZERO)] = 1'b0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard, r0 = 0.
// Ports: clk, rst (sync, active-low); NUM_RD read ports (rd_addr,
// rd_data, rd_busy); NUM_WR write ports (wr_en, wr_addr, wr_data);
// issue_en/issue_addr set busy, flush clears busy, any_busy = OR of busy.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to read ports.
module regfile_mp
    import lc_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [NUM_RD*WORD_W-1:0]          rd_data,
    output logic [NUM_RD-1:0]                 rd_busy,
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR*$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [NUM_WR*WORD_W-1:0]          wr_data,
    input  logic                              issue_en,
    input  logic [$clog2(NUM_REGS)-1:0]       issue_addr,
    input  logic                              flush,
    output logic                              any_busy
);

    localparam int AW = $clog2(NUM_REGS);

    logic [WORD_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS-1:0]        busy;
    logic [NUM_REGS-1:0]        busy_nxt;
    logic [NUM_REGS-1:0]        reg_we;
    logic [NUM_REGS*WORD_W-1:0] reg_wdata;

    regfile_wr_arb #(
        .WORD_W   (WORD_W),
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_arb (
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata)
    );

    // Flush, then writeback clears, then issue sets (new producer wins).
    always_comb begin
        busy_nxt = busy;
        if (flush)
            busy_nxt = '0;
        busy_nxt = busy_nxt & ~reg_we;
        if (issue_en)
            busy_nxt[issue_addr] = 1'b1;
        busy_nxt[AW'(REG_ZERO)] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (reg_we[r])
                    regs[r] <= reg_wdata[r*WORD_W +: WORD_W];
            busy <= busy_nxt;
        end
    end

    always_comb begin
        logic [AW-1:0]     ra;
        logic [WORD_W-1:0] rdv;
        logic              rbv;
        ra      = '0;
        rdv     = '0;
        rbv     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = rd_addr[i*AW +: AW];
            rdv = regs[ra];
            rbv = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // reg_we[0] is never set, so r0 is never forwarded.
            if (reg_we[ra]) begin
                rdv = reg_wdata[ra*WORD_W +: WORD_W];
                rbv = issue_en && (issue_addr == ra);
            end
`endif
            rd_data[i*WORD_W +: WORD_W] = rdv;
            rd_busy[i] = rbv;
        end
    end

    assign any_busy = |busy;

endmodule
